irq_notify_axil_master: RTL and testbench
=========================================

Name: irq_notify_axil_master

Overview:
- Downstream of the PLIC wrapper. Consumes the per-target external-interrupt levels (eip) produced by rv_plic.
- For each target, forwards every change of level to the core's interrupt CSR window as one AXI4-Lite write on its own master port. Target 0 is M-mode; target 1 is S-mode.
- Coalesces level changes per target and serializes writes: at most one AXI transaction is outstanding at any time.

Parameters:
- num_targets_p, 2, number of interrupt targets (width of irq_i).
- axil_data_width_p, 32, AXI4-Lite data width.
- axil_addr_width_p, 32, AXI4-Lite address width.
- base_addr_p, 'h30_b000, address written for target 0.
- target_stride_p, 4, address increment per target. Address of target t = base_addr_p + t*target_stride_p.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- irq_i  in  num_targets_p  per-target interrupt level from PLIC.
- m_axil_awaddr_o  out  axil_addr_width_p  write address.
- m_axil_awprot_o  out  3  constant 3'b000.
- m_axil_awvalid_o  out  1  write address valid.
- m_axil_awready_i  in  1  write address ready.
- m_axil_wdata_o  out  axil_data_width_p  zero-extended level bit.
- m_axil_wstrb_o  out  axil_data_width_p/8  constant all ones.
- m_axil_wvalid_o  out  1  write data valid.
- m_axil_wready_i  in  1  write data ready.
- m_axil_bresp_i  in  2  write response.
- m_axil_bvalid_i  in  1  response valid.
- m_axil_bready_o  out  1  response ready.
- m_axil_araddr_o  out  axil_addr_width_p  constant 0; read channel unused.
- m_axil_arprot_o  out  3  constant 0.
- m_axil_arvalid_o  out  1  constant 0.
- m_axil_arready_i  in  1  ignored.
- m_axil_rdata_i  in  axil_data_width_p  ignored.
- m_axil_rresp_i  in  2  ignored.
- m_axil_rvalid_i  in  1  ignored.
- m_axil_rready_o  out  1  constant 1 (drains any stray response).
- busy_o  out  1  high whenever the state is not IDLE.
- err_o  out  1  sticky; set on any bresp != 2'b00; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_ni=0) values:
  - irq_r = 0, sent_r = 0, state = IDLE, rr pointer = 0.
  - awvalid, wvalid, bready, busy_o, err_o = 0.
  - awaddr and wdata = 0.
- irq_r registers irq_i every cycle. pending[t] = irq_r[t] ^ sent_r[t].
- Coalescing: a pulse shorter than the time to service a target produces no write if the level returns to sent_r[t] before that target is selected.
- States:
  - IDLE: if pending != 0, select the first pending target at or after the rr pointer (round-robin, wrap at num_targets_p-1 -> 0). Latch sel_r = t and lvl_r = irq_r[t]. Drive awaddr/wdata from these latches. Go to SEND. rr pointer <= t+1 mod num_targets_p.
  - SEND: awvalid and wvalid both rise on entry. Each drops on its own handshake; the two may complete in the same or different cycles, in either order. When both have completed, go to WAIT_B.
  - WAIT_B: bready = 1. On bvalid, sent_r[sel_r] <= lvl_r, set err_o if bresp != 0, go to IDLE.
- Latency: irq_i change at edge N -> awvalid/wvalid high from edge N+2, given IDLE and no competing pending target.
- awaddr and wdata stay stable from SEND entry until the handshake; valids never drop before their handshake.
- Simultaneous events:
  - If irq changes during SEND/WAIT_B for the target in flight, mismatch persists after the update and a new write follows.
  - Two targets changing in the same cycle are served back to back in rr order.
- Write data is {(axil_data_width_p-1)'0, lvl_r}.
- Reset mid-transaction drops all valids immediately. The bench must not complete the dangling handshake.

Optional Feature:
- Macro IRQ_NOTIFY_RETRY_EN.
- Defined: on bresp != 0, sent_r is NOT updated, so the target stays pending and is rewritten after arbitration. err_o is still set.
- Undefined: a failed write updates sent_r like a successful one (fire-and-forget); only err_o records the failure.

Test Plan:
- irq_i 00->10, slaves always ready, bresp=0 -> one write: awaddr 'h30_b004, wdata 1; awvalid rises 2 cycles after change; busy_o returns 0.
- irq_i 00->11 in one cycle -> writes to 'h30_b000 then 'h30_b004, both wdata 1, in that order; the next simultaneous change is served starting at target 0 again because the rr pointer has wrapped.
- awready held low 5 cycles while wready is immediate -> wvalid drops after 1 cycle; awvalid held with stable addr; bready asserted only after AW completes.
- irq_i[0] pulses high for 1 cycle while a target-1 write is in WAIT_B -> no write to 'h30_b000 afterwards.
- bresp=2'b10 on a write of 1 to target 0 -> err_o = 1. With IRQ_NOTIFY_RETRY_EN, the identical write is reissued; without it, no further write occurs.
- rst_ni pulled low during SEND -> awvalid/wvalid go low asynchronously. After release with irq_i=01, one write of 1 to 'h30_b000 is issued.

Source files
------------

// File: rtl/irq_notify_axil_master_if.sv
// AXI4-Lite bundle for the interrupt-notify master: master drives AW/W/AR and
// the B/R ready signals, slave answers with readies, responses and read data.
interface irq_notify_axil_master_if #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
);
  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/irq_notify_axil_master.sv
// Forwards per-target interrupt level changes as single AXI4-Lite writes, one at a time.
// Optional IRQ_NOTIFY_RETRY_EN: an error response leaves the target pending so it is rewritten.
//
// state  | meaning
// IDLE   | no transaction; pick the next pending target round-robin
// SEND   | AW and W valids up, each drops on its own handshake
// WAIT_B | both channels accepted, bready high until the response
module irq_notify_axil_master #(
  parameter int unsigned num_targets_p     = 2,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] base_addr_p = 'h30_b000,
  parameter int unsigned target_stride_p   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [num_targets_p-1:0] irq_i,
  irq_notify_axil_master_if.master m_axil,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned tgt_w_lp = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  state_e                         state_q;
  logic [num_targets_p-1:0]       irq_r;
  logic [num_targets_p-1:0]       sent_r;
  logic [num_targets_p-1:0]       pending;
  logic [tgt_w_lp-1:0]            rr_r;
  logic [tgt_w_lp-1:0]            sel_r;
  logic [tgt_w_lp-1:0]            pick_idx;
  logic [tgt_w_lp-1:0]            cand;
  logic                           pick_vld;
  logic                           lvl_r;
  logic                           awvalid_r;
  logic                           wvalid_r;
  logic                           bready_r;
  logic [axil_addr_width_p-1:0]   awaddr_r;
  logic [axil_data_width_p-1:0]   wdata_r;
  logic                           unused_axil;

  assign pending = irq_r ^ sent_r;

  // First pending target at or after the round-robin pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < num_targets_p; k++) begin
      cand = tgt_w_lp'((32'(rr_r) + k) % num_targets_p);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      irq_r     <= '0;
      sent_r    <= '0;
      rr_r      <= '0;
      sel_r     <= '0;
      lvl_r     <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      err_o     <= 1'b0;
    end else begin
      irq_r <= irq_i;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            sel_r     <= pick_idx;
            lvl_r     <= irq_r[pick_idx];
            awaddr_r  <= base_addr_p + axil_addr_width_p'(32'(pick_idx) * target_stride_p);
            wdata_r   <= axil_data_width_p'(irq_r[pick_idx]);
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            rr_r      <= tgt_w_lp'((32'(pick_idx) + 32'd1) % num_targets_p);
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (m_axil.awready) awvalid_r <= 1'b0;
          if (m_axil.wready)  wvalid_r  <= 1'b0;
          if ((!awvalid_r || m_axil.awready) && (!wvalid_r || m_axil.wready)) begin
            bready_r <= 1'b1;
            state_q  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (m_axil.bvalid) begin
            bready_r <= 1'b0;
`ifdef IRQ_NOTIFY_RETRY_EN
            if (m_axil.bresp == 2'b00) sent_r[sel_r] <= lvl_r;
`else
            sent_r[sel_r] <= lvl_r;
`endif
            if (m_axil.bresp != 2'b00) err_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);

  assign m_axil.awaddr  = awaddr_r;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_r;
  assign m_axil.wdata   = wdata_r;
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = wvalid_r;
  assign m_axil.bready  = bready_r;
  // Read channel is never used; rready stays high to swallow anything stray.
  assign m_axil.araddr  = '0;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = 1'b0;
  assign m_axil.rready  = 1'b1;

  assign unused_axil = ^{m_axil.arready, m_axil.rdata, m_axil.rresp, m_axil.rvalid};

endmodule

// File: tb/tb_irq_notify_axil_master.sv
// Bench for irq_notify_axil_master: directed scenarios plus randomized irq traffic against
// a randomly-stalling AXI slave, scored by a per-target "last level delivered" model.
module tb_irq_notify_axil_master;

  localparam int          NT     = 2;
  localparam logic [31:0] BASE   = 32'h0030_b000;
  localparam int          STRIDE = 4;
`ifdef IRQ_NOTIFY_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NT-1:0] irq;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  // slave configuration, set by the main sequence
  int cfg_rdy_pct   = 100;
  int cfg_b_delay   = 0;
  bit cfg_aw_block  = 1'b0;
  bit cfg_err_once  = 1'b0;

  // reference model: last level successfully delivered per target
  logic [NT-1:0] model_sent;
  wr_t           wr_q[$];

  irq_notify_axil_master_if #(.addr_width_p(32), .data_width_p(32)) axil ();

  irq_notify_axil_master #(
    .num_targets_p    (NT),
    .axil_data_width_p(32),
    .axil_addr_width_p(32),
    .base_addr_p      (BASE),
    .target_stride_p  (STRIDE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .irq_i (irq),
    .m_axil(axil),
    .busy_o(busy),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic score(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    logic [31:0] off;
    int          t;
    bit          ok;
    off = addr - BASE;
    t   = int'(off / STRIDE);
    ok  = (addr >= BASE) && (off % STRIDE == 0) && (t < NT);
    chk("wr_addr_valid", 64'(ok), 64'(1));
    chk("wr_data_is_bit", 64'(data <= 32'd1), 64'(1));
    if (ok) begin
      chk("wr_is_level_change", 64'(data[0] != model_sent[t]), 64'(1));
      if (!(RETRY && resp != 2'b00)) model_sent[t] = data[0];
    end
    wr_q.push_back('{addr, data, resp});
  endtask

  // AXI slave + monitor; works at negedge so DUT outputs are settled
  initial begin
    bit          s_aw_seen, s_w_seen;
    logic [31:0] s_addr, s_data;
    int          b_cnt;
    logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    logic [31:0] p_awaddr, p_wdata;
    s_aw_seen = 0; s_w_seen = 0; s_addr = '0; s_data = '0; b_cnt = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
    p_awaddr = '0; p_wdata = '0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    model_sent = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_aw_seen = 0; s_w_seen = 0; b_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
        axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
        model_sent = '0;
      end else begin
        if (p_awv && p_awr) begin s_aw_seen = 1; s_addr = p_awaddr; end
        if (p_wv && p_wr) begin s_w_seen = 1; s_data = p_wdata; end
        if (p_awv && !p_awr) begin
          chk("aw_valid_held", 64'(axil.awvalid), 64'(1));
          chk("aw_addr_stable", 64'(axil.awaddr), 64'(p_awaddr));
        end
        if (p_wv && !p_wr) begin
          chk("w_valid_held", 64'(axil.wvalid), 64'(1));
          chk("w_data_stable", 64'(axil.wdata), 64'(p_wdata));
        end
        if (p_bv && p_br) begin
          score(s_addr, s_data, axil.bresp);
          axil.bvalid = 1'b0;
          axil.bresp  = 2'b00;
          s_aw_seen = 0; s_w_seen = 0;
        end
        if (axil.bready) chk("bready_after_aw_w", 64'(s_aw_seen && s_w_seen), 64'(1));
        if (s_aw_seen && s_w_seen && !axil.bvalid) begin
          if (b_cnt >= cfg_b_delay) begin
            axil.bvalid  = 1'b1;
            axil.bresp   = cfg_err_once ? 2'b10 : 2'b00;
            cfg_err_once = 1'b0;
            b_cnt        = 0;
          end else begin
            b_cnt++;
          end
        end
        axil.awready = !cfg_aw_block && (int'($urandom_range(99)) < cfg_rdy_pct);
        axil.wready  = int'($urandom_range(99)) < cfg_rdy_pct;
        p_awv = axil.awvalid; p_awr = axil.awready; p_awaddr = axil.awaddr;
        p_wv  = axil.wvalid;  p_wr  = axil.wready;  p_wdata  = axil.wdata;
        p_bv  = axil.bvalid;  p_br  = axil.bready;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget && quiet < 6; i++) begin
      @(posedge clk); #1;
      if (busy) quiet = 0;
      else quiet++;
    end
    chk("idle_reached", 64'(quiet >= 6), 64'(1));
  endtask

  task automatic wait_awvalid(input string tag);
    for (int i = 0; i < 20 && !axil.awvalid; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 64'(axil.awvalid), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_n;
    axil.arready = 1'b0; axil.rdata = '0; axil.rresp = 2'b00; axil.rvalid = 1'b0;
    rst_n = 1'b0;
    irq   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", 64'(axil.awvalid), 64'(0));
    chk("rst_wvalid",  64'(axil.wvalid),  64'(0));
    chk("rst_bready",  64'(axil.bready),  64'(0));
    chk("rst_busy",    64'(busy),         64'(0));
    chk("rst_err",     64'(err),          64'(0));
    chk("rst_awaddr",  64'(axil.awaddr),  64'(0));
    chk("rst_wdata",   64'(axil.wdata),   64'(0));
    chk("awprot_zero", 64'(axil.awprot),  64'(0));
    chk("wstrb_ones",  64'(axil.wstrb),   64'('hf));
    chk("arvalid_zero",64'(axil.arvalid), 64'(0));
    chk("araddr_zero", 64'(axil.araddr),  64'(0));
    chk("rready_one",  64'(axil.rready),  64'(1));
    rst_n = 1'b1;

    // single change on target 1, latency and address
    @(posedge clk); #1;
    irq = 2'b10;
    @(posedge clk); #1;
    chk("t1_awvalid_edge1", 64'(axil.awvalid), 64'(0));
    @(posedge clk); #1;
    chk("t1_awvalid_edge2", 64'(axil.awvalid), 64'(1));
    chk("t1_wvalid_edge2",  64'(axil.wvalid),  64'(1));
    chk("t1_awaddr", 64'(axil.awaddr), 64'(BASE + 4));
    chk("t1_wdata",  64'(axil.wdata),  64'(1));
    wait_idle(100);
    chk("t1_nwrites", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() == 1) begin
      chk("t1_wr_addr", 64'(wr_q[0].addr), 64'(BASE + 4));
      chk("t1_wr_data", 64'(wr_q[0].data), 64'(1));
    end
    chk("t1_busy_low", 64'(busy), 64'(0));

    // simultaneous changes, round-robin order and wrap
    irq = 2'b00;
    wait_idle(100);
    wr_q.delete();
    irq = 2'b11;
    wait_idle(100);
    chk("t2a_nwrites", 64'(wr_q.size()), 64'(2));
    if (wr_q.size() == 2) begin
      chk("t2a_first_addr",  64'(wr_q[0].addr), 64'(BASE));
      chk("t2a_first_data",  64'(wr_q[0].data), 64'(1));
      chk("t2a_second_addr", 64'(wr_q[1].addr), 64'(BASE + 4));
      chk("t2a_second_data", 64'(wr_q[1].data), 64'(1));
    end
    wr_q.delete();
    irq = 2'b00;
    wait_idle(100);
    chk("t2b_nwrites", 64'(wr_q.size()), 64'(2));
    if (wr_q.size() == 2) begin
      chk("t2b_first_addr",  64'(wr_q[0].addr), 64'(BASE));
      chk("t2b_second_addr", 64'(wr_q[1].addr), 64'(BASE + 4));
      chk("t2b_first_data",  64'(wr_q[0].data), 64'(0));
    end

    // AW stalled 5 cycles, W accepted immediately
    wr_q.delete();
    cfg_aw_block = 1'b1;
    @(posedge clk); #1;
    irq = 2'b01;
    wait_awvalid("t3_awvalid_rise");
    chk("t3_wvalid_rise", 64'(axil.wvalid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_wvalid_dropped", 64'(axil.wvalid),  64'(0));
      chk("t3_awvalid_held",   64'(axil.awvalid), 64'(1));
      chk("t3_awaddr_stable",  64'(axil.awaddr),  64'(BASE));
      chk("t3_bready_low",     64'(axil.bready),  64'(0));
    end
    cfg_aw_block = 1'b0;
    wait_idle(100);
    chk("t3_nwrites", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() == 1) begin
      chk("t3_wr_addr", 64'(wr_q[0].addr), 64'(BASE));
      chk("t3_wr_data", 64'(wr_q[0].data), 64'(1));
    end

    // short pulse on target 0 while target 1 waits for its response
    irq = 2'b00;
    wait_idle(100);
    wr_q.delete();
    cfg_b_delay = 6;
    irq = 2'b10;
    for (int i = 0; i < 20 && !axil.bready; i++) begin
      @(posedge clk); #1;
    end
    chk("t4_bready_seen", 64'(axil.bready), 64'(1));
    irq = 2'b11;
    @(posedge clk); #1;
    irq = 2'b10;
    chk("t4_still_busy", 64'(busy), 64'(1));
    wait_idle(100);
    cfg_b_delay = 0;
    chk("t4_nwrites", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() == 1) chk("t4_wr_addr", 64'(wr_q[0].addr), 64'(BASE + 4));

    // error response on a write of 1 to target 0
    wr_q.delete();
    cfg_err_once = 1'b1;
    irq = 2'b11;
    wait_idle(100);
    chk("t5_err_set", 64'(err), 64'(1));
    exp_n = RETRY ? 2 : 1;
    chk("t5_nwrites", 64'(wr_q.size()), 64'(exp_n));
    if (wr_q.size() > 0) chk("t5_first_resp", 64'(wr_q[0].resp), 64'(2));
    foreach (wr_q[i]) begin
      chk("t5_wr_addr", 64'(wr_q[i].addr), 64'(BASE));
      chk("t5_wr_data", 64'(wr_q[i].data), 64'(1));
    end

    // reset in the middle of SEND
    cfg_aw_block = 1'b1;
    @(posedge clk); #1;
    irq = 2'b01;
    wait_awvalid("t6_awvalid_rise");
    chk("t6_awaddr", 64'(axil.awaddr), 64'(BASE + 4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid_async", 64'(axil.awvalid), 64'(0));
    chk("t6_wvalid_async",  64'(axil.wvalid),  64'(0));
    chk("t6_busy_async",    64'(busy),         64'(0));
    chk("t6_err_cleared",   64'(err),          64'(0));
    cfg_aw_block = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr_q.delete();
    rst_n = 1'b1;
    wait_idle(100);
    chk("t6_nwrites", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() == 1) begin
      chk("t6_wr_addr", 64'(wr_q[0].addr), 64'(BASE));
      chk("t6_wr_data", 64'(wr_q[0].data), 64'(1));
    end

    // randomized traffic with random slave stalls
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) begin
        cfg_rdy_pct = int'($urandom_range(100, 20));
        cfg_b_delay = int'($urandom_range(3, 0));
      end
      @(posedge clk); #1;
      if ($urandom_range(99) < 15) begin
        int j;
        j = int'($urandom_range(NT - 1));
        irq[j] = ~irq[j];
      end
    end
    wait_idle(500);
    for (int t = 0; t < NT; t++) chk("rand_final_level", 64'(model_sent[t]), 64'(irq[t]));
    chk("rand_err_clear", 64'(err), 64'(0));
    chk("rand_busy_low", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
